// File: rtl/sr_drive_pkg.sv
// Shared types and defaults for the SR flip-flop drive sequencer.
package sr_drive_pkg;

    localparam int DB_CYCLES_DEF = 4;
    localparam int HOLD_DEF      = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE_S = 2'd1,
        DRIVE_R = 2'd2,
        CHECK   = 2'd3
    } state_e;

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchronizer followed by a debouncer; emits a registered
// one-cycle pulse on each accepted 0->1 change of the filtered level.
module sr_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic c,
    input  logic rs,
    input  logic raw_i,
    output logic rise_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic       level_q;
    logic       level_d;
    logic       rise_q;
    logic       rise_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // The count only advances while the synchronized value disagrees with
    // the filtered level; any agreeing cycle restarts it from zero.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = 8'd0;
        if (sync2_q != level_q) begin
            if (cnt_q == 8'(DB_CYCLES - 1)) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge c) begin
        if (rs) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/sr_drive_seq.sv
// Debounced set/reset command sequencer driving a downstream SR flip-flop,
// with readback check of its q output and sticky fail/conflict flags.
module sr_drive_seq
    import sr_drive_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int HOLD      = HOLD_DEF
) (
    input  logic c,
    input  logic rs,
    input  logic set_req,
    input  logic rst_req,
    input  logic q_fb,
    input  logic clr_flags,
    output logic s,
    output logic r,
    output logic busy,
    output logic done,
    output logic fail,
    output logic conflict
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    logic [1:0] raw_req;
    logic [1:0] req_evt;

    assign raw_req = {rst_req, set_req};

    // Bit 0 carries the set request, bit 1 the reset request.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_db
            sr_debounce #(
                .DB_CYCLES(DB_CYCLES)
            ) u_db (
                .c      (c),
                .rs     (rs),
                .raw_i  (raw_req[gi]),
                .rise_o (req_evt[gi])
            );
        end
    endgenerate

    state_e     state_q;
    state_e     state_d;
    logic [3:0] hold_q;
    logic [3:0] hold_d;
    logic       cmd_set_q;
    logic       cmd_set_d;
    logic       s_q;
    logic       s_d;
    logic       r_q;
    logic       r_d;
    logic       done_q;
    logic       done_d;
    logic       fail_q;
    logic       fail_d;
    logic       conflict_q;
    logic       conflict_d;
    logic       set_pend_q;
    logic       set_pend_d;
    logic       rst_pend_q;
    logic       rst_pend_d;
    logic       set_cmd;
    logic       rst_cmd;
    logic       check_ok;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        cmd_set_d  = cmd_set_q;
        done_d     = 1'b0;
        set_pend_d = set_pend_q;
        rst_pend_d = rst_pend_q;
        fail_d     = clr_flags ? 1'b0 : fail_q;
        conflict_d = clr_flags ? 1'b0 : conflict_q;
        set_cmd    = req_evt[0] | set_pend_q;
        rst_cmd    = req_evt[1] | rst_pend_q;
        check_ok   = (q_fb == cmd_set_q);

        case (state_q)
            IDLE: begin
                if (set_cmd && rst_cmd) begin
                    conflict_d = 1'b1;
                    set_pend_d = 1'b0;
                    rst_pend_d = 1'b0;
                end else if (set_cmd) begin
                    set_pend_d = 1'b0;
                    cmd_set_d  = 1'b1;
                    if (q_fb) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = DRIVE_S;
                        hold_d  = HOLD_LAST;
                    end
                end else if (rst_cmd) begin
                    rst_pend_d = 1'b0;
                    cmd_set_d  = 1'b0;
                    if (!q_fb) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = DRIVE_R;
                        hold_d  = HOLD_LAST;
                    end
                end
            end
            DRIVE_S, DRIVE_R: begin
                if (hold_q == 4'd0) begin
                    state_d = CHECK;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (!check_ok) begin
                    fail_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Requests arriving while a command is in flight are remembered once.
        if (state_q != IDLE) begin
            if (req_evt[0]) begin
                set_pend_d = 1'b1;
            end
            if (req_evt[1]) begin
                rst_pend_d = 1'b1;
            end
        end

        s_d = (state_d == DRIVE_S);
        r_d = (state_d == DRIVE_R);
    end

    always_ff @(posedge c) begin
        if (rs) begin
            state_q    <= IDLE;
            hold_q     <= 4'd0;
            cmd_set_q  <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            conflict_q <= 1'b0;
            set_pend_q <= 1'b0;
            rst_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            cmd_set_q  <= cmd_set_d;
            s_q        <= s_d;
            r_q        <= r_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            conflict_q <= conflict_d;
            set_pend_q <= set_pend_d;
            rst_pend_q <= rst_pend_d;
        end
    end

    // A successful check reports done during the CHECK cycle itself.
    assign done     = done_q | ((state_q == CHECK) && check_ok);
    assign s        = s_q;
    assign r        = r_q;
    assign busy     = (state_q != IDLE);
    assign fail     = fail_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_drive_seq.sv
// Directed bench for sr_drive_seq: a cycle-level behavioural model checked
// every cycle, plus hand-computed expectations at key edges.
module tb_sr_drive_seq;

    localparam int DB   = 4;
    localparam int HOLD = 2;

    logic c         = 1'b0;
    logic rs        = 1'b0;
    logic set_req   = 1'b0;
    logic rst_req   = 1'b0;
    logic q_fb      = 1'b0;
    logic clr_flags = 1'b0;
    logic s;
    logic r;
    logic busy;
    logic done;
    logic fail;
    logic conflict;

    int   tests     = 0;
    int   fails     = 0;
    int   en        = 0;
    bit   armed     = 1'b0;
    bit   stuck_en  = 1'b0;
    bit   stuck_val = 1'b0;

    sr_drive_seq #(
        .DB_CYCLES(DB),
        .HOLD     (HOLD)
    ) dut (
        .c        (c),
        .rs       (rs),
        .set_req  (set_req),
        .rst_req  (rst_req),
        .q_fb     (q_fb),
        .clr_flags(clr_flags),
        .s        (s),
        .r        (r),
        .busy     (busy),
        .done     (done),
        .fail     (fail),
        .conflict (conflict)
    );

    always #5 c = ~c;

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at t=%0t edge=%0d: got %b expected %b", name, $time, en, act, exp);
        end
    endtask

    // Downstream SR flip-flop, optionally stuck, updated just after each edge.
    always @(posedge c) begin
        #1;
        if (stuck_en)  q_fb = stuck_val;
        else if (rs)   q_fb = 1'b0;
        else if (s)    q_fb = 1'b1;
        else if (r)    q_fb = 1'b0;
    end

    // ---------------- behavioural model ----------------
    bit raw_h [2][4096];
    bit syn_h [2][4096];
    int h_len   = 2;
    int syn_len = 0;
    bit filt [2];
    bit evt_prev [2];
    int job   = 0;   // 0 none, 1 set command, 2 reset command
    int age   = 0;   // edges since the command started driving
    bit spend = 0;
    bit rpend = 0;
    bit m_fail = 0;
    bit m_conf = 0;
    bit m_skip = 0;
    bit want_set;
    bit want_rst;
    bit sv;
    bit same;

    always @(posedge c) begin
        if (rs) begin
            for (int k = 0; k < 2; k++) begin
                raw_h[k][0] = 1'b0;
                raw_h[k][1] = 1'b0;
                filt[k]     = 1'b0;
                evt_prev[k] = 1'b0;
            end
            h_len   = 2;
            syn_len = 0;
            job     = 0;
            age     = 0;
            spend   = 0;
            rpend   = 0;
            m_fail  = 0;
            m_conf  = 0;
            m_skip  = 0;
        end else begin
            m_skip = 0;
            if (clr_flags) begin
                m_fail = 0;
                m_conf = 0;
            end
            if (job == 0) begin
                want_set = evt_prev[0] | spend;
                want_rst = evt_prev[1] | rpend;
                if (want_set && want_rst) begin
                    m_conf = 1;
                    spend  = 0;
                    rpend  = 0;
                end else if (want_set) begin
                    spend = 0;
                    if (q_fb) m_skip = 1;
                    else begin job = 1; age = 0; end
                end else if (want_rst) begin
                    rpend = 0;
                    if (!q_fb) m_skip = 1;
                    else begin job = 2; age = 0; end
                end
            end else begin
                if (evt_prev[0]) spend = 1;
                if (evt_prev[1]) rpend = 1;
                if (age == HOLD) begin
                    if (q_fb != (job == 1)) m_fail = 1;
                    job = 0;
                end else begin
                    age++;
                end
            end
            // Filtered level follows once the last DB synchronized samples
            // (raw delayed by two edges) all agree on a new value.
            raw_h[0][h_len] = set_req;
            raw_h[1][h_len] = rst_req;
            h_len++;
            for (int k = 0; k < 2; k++) begin
                syn_h[k][syn_len] = raw_h[k][h_len - 3];
            end
            syn_len++;
            for (int k = 0; k < 2; k++) begin
                evt_prev[k] = 1'b0;
                sv   = syn_h[k][syn_len - 1];
                same = (syn_len >= DB);
                for (int j = 0; j < DB && same; j++) begin
                    if (syn_h[k][syn_len - 1 - j] != sv) same = 0;
                end
                if (same && sv != filt[k]) begin
                    filt[k]     = sv;
                    evt_prev[k] = sv;
                end
            end
        end
    end

    always @(posedge c) begin
        #3;
        if (armed) begin
            chk("model_s", s, (job == 1) && (age < HOLD));
            chk("model_r", r, (job == 2) && (age < HOLD));
            chk("model_busy", busy, job != 0);
            chk("model_done", done,
                m_skip | ((job != 0) && (age == HOLD) && (q_fb == (job == 1))));
            chk("model_fail", fail, m_fail);
            chk("model_conflict", conflict, m_conf);
            chk("never_s_and_r", s & r, 1'b0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(negedge c);
        rs        = 1'b1;
        set_req   = 1'b0;
        rst_req   = 1'b0;
        clr_flags = 1'b0;
        @(posedge c);
        #2;
        armed = 1'b1;
        chk("rst_s", s, 1'b0);
        chk("rst_r", r, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_fail", fail, 1'b0);
        chk("rst_conflict", conflict, 1'b0);
        @(negedge c);
        rs = 1'b0;
        en = 0;
    endtask

    task automatic goto(input int n);
        while (en < n) begin
            @(posedge c);
            en++;
        end
        #2;
    endtask

    initial begin
        // Set command, q_fb follows s.
        do_reset();
        set_req = 1'b1;
        goto(6);  chk("t1_s_e6", s, 1'b0);
        goto(7);  chk("t1_s_e7", s, 1'b1);
        goto(8);  chk("t1_s_e8", s, 1'b1);
        goto(9);  chk("t1_s_e9", s, 1'b0); chk("t1_done_e9", done, 1'b1); chk("t1_busy_e9", busy, 1'b1);
        goto(10); chk("t1_done_e10", done, 1'b0); chk("t1_fail_e10", fail, 1'b0); chk("t1_busy_e10", busy, 1'b0);
        @(negedge c);
        set_req = 1'b0;
        goto(20); chk("t1_fall_busy", busy, 1'b0);

        // Three-cycle glitch is rejected.
        do_reset();
        set_req = 1'b1;
        goto(3);
        @(negedge c);
        set_req = 1'b0;
        for (int e = 4; e <= 16; e++) begin
            goto(e);
            chk("t2_glitch_s", s, 1'b0);
            chk("t2_glitch_done", done, 1'b0);
        end

        // Simultaneous set and reset.
        do_reset();
        set_req = 1'b1;
        rst_req = 1'b1;
        goto(6);  chk("t3_conf_e6", conflict, 1'b0);
        goto(7);  chk("t3_conf_e7", conflict, 1'b1); chk("t3_s_e7", s, 1'b0); chk("t3_r_e7", r, 1'b0);
        goto(12); chk("t3_conf_e12", conflict, 1'b1); chk("t3_busy_e12", busy, 1'b0);
        @(negedge c);
        clr_flags = 1'b1;
        goto(13); chk("t3_conf_clr", conflict, 1'b0);
        @(negedge c);
        clr_flags = 1'b0;

        // Reset command with q_fb stuck high.
        stuck_en  = 1'b1;
        stuck_val = 1'b1;
        do_reset();
        rst_req = 1'b1;
        goto(7);  chk("t4_r_e7", r, 1'b1);
        goto(8);  chk("t4_r_e8", r, 1'b1);
        goto(9);  chk("t4_r_e9", r, 1'b0); chk("t4_done_e9", done, 1'b0); chk("t4_busy_e9", busy, 1'b1);
        goto(10); chk("t4_fail_e10", fail, 1'b1); chk("t4_done_e10", done, 1'b0);

        // Skip: set requested while q_fb already high.
        do_reset();
        set_req = 1'b1;
        goto(7);  chk("t7_skip_done", done, 1'b1); chk("t7_skip_s", s, 1'b0); chk("t7_skip_busy", busy, 1'b0);
        goto(8);  chk("t7_skip_done_e8", done, 1'b0);
        @(negedge c);
        stuck_en = 1'b0;

        // Reset request arriving during DRIVE_S is served afterwards.
        do_reset();
        set_req = 1'b1;
        goto(1);
        @(negedge c);
        rst_req = 1'b1;
        goto(7);  chk("t5_s_e7", s, 1'b1);
        goto(9);  chk("t5_done_e9", done, 1'b1);
        goto(10); chk("t5_busy_e10", busy, 1'b0);
        goto(11); chk("t5_r_e11", r, 1'b1);
        goto(12); chk("t5_r_e12", r, 1'b1);
        goto(13); chk("t5_r_e13", r, 1'b0); chk("t5_done_e13", done, 1'b1);
        goto(14); chk("t5_fail_e14", fail, 1'b0); chk("t5_done_e14", done, 1'b0);

        // Reset in the middle of DRIVE_S.
        do_reset();
        set_req = 1'b1;
        goto(7);  chk("t6_s_e7", s, 1'b1);
        @(negedge c);
        rs      = 1'b1;
        set_req = 1'b0;
        goto(8);  chk("t6_s_e8", s, 1'b0); chk("t6_busy_e8", busy, 1'b0); chk("t6_done_e8", done, 1'b0);
        chk("t6_fail_e8", fail, 1'b0); chk("t6_conf_e8", conflict, 1'b0);
        @(negedge c);
        rs = 1'b0;
        goto(20); chk("t6_done_e20", done, 1'b0); chk("t6_busy_e20", busy, 1'b0);

        @(negedge c);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
